// File: rtl/rvc_compressor.sv
// Re-encodes RV32I instructions into RVC parcels where an exact equivalent exists and packs
// the 16/32-bit parcel stream little-endian into aligned 32-bit words (one-entry output register).
module rvc_compressor #(
   parameter int ENABLE_RVC = 1,
   parameter int CNT_W      = 16
) (
   input  logic             I_clk,
   input  logic             I_rst_n,
   input  logic             I_valid,
   input  logic [31:0]      I_data,
   output logic             O_accept,
   input  logic             I_flush,
   output logic             O_flush_done,
   output logic             O_valid,
   output logic [31:0]      O_word,
   input  logic             I_ready,
   output logic             O_err,
   output logic [CNT_W-1:0] O_cnt_comp,
   output logic [CNT_W-1:0] O_cnt_words
);

   typedef enum logic {ST_EMPTY, ST_HALF} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic [15:0]      hbuf_q, hbuf_d;
   logic             out_vld_q, out_vld_d;
   logic [31:0]      out_word_q, out_word_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_comp_q, cnt_comp_d;
   logic [CNT_W-1:0] cnt_words_q, cnt_words_d;

   logic slot_free, take, flush_go, comp_inc;

   // Instruction field decode
   logic [6:0] op;
   logic [2:0] f3;
   logic [6:0] f7;
   logic [4:0] rd, rs1, rs2;
   logic       imm_zero, imm_small, lw_off_ok, sw_off_ok;
   logic       is_addi, is_slli, is_add, is_jalr, is_lw, is_sw;
   logic       c_hit;
   logic [15:0] c_par;

   assign op  = I_data[6:0];
   assign rd  = I_data[11:7];
   assign f3  = I_data[14:12];
   assign rs1 = I_data[19:15];
   assign rs2 = I_data[24:20];
   assign f7  = I_data[31:25];

   assign imm_zero  = (I_data[31:20] == 12'h000);
   assign imm_small = (I_data[31:25] == {7{I_data[25]}});
   // Offsets must be word aligned and within [0,127]
   assign lw_off_ok = (I_data[31:27] == 5'd0) && (I_data[21:20] == 2'd0);
   assign sw_off_ok = (I_data[31:27] == 5'd0) && (I_data[8:7] == 2'd0);

   assign is_addi = (op == 7'b0010011) && (f3 == 3'b000);
   assign is_slli = (op == 7'b0010011) && (f3 == 3'b001) && (f7 == 7'b0000000);
   assign is_add  = (op == 7'b0110011) && (f3 == 3'b000) && (f7 == 7'b0000000);
   assign is_jalr = (op == 7'b1100111) && (f3 == 3'b000);
   assign is_lw   = (op == 7'b0000011) && (f3 == 3'b010);
   assign is_sw   = (op == 7'b0100011) && (f3 == 3'b010);

   always_comb begin
      c_hit = 1'b0;
      c_par = 16'h0000;
      if (is_addi && rd == 5'd0 && rs1 == 5'd0 && imm_zero) begin
         c_hit = 1'b1;
         c_par = 16'h0001;
      end else if (is_addi && rs1 == 5'd0 && rd != 5'd0 && imm_small) begin
         c_hit = 1'b1;
         c_par = {3'b010, I_data[25], rd, I_data[24:20], 2'b01};
      end else if (is_addi && rd == rs1 && rd != 5'd0 && !imm_zero && imm_small) begin
         c_hit = 1'b1;
         c_par = {3'b000, I_data[25], rd, I_data[24:20], 2'b01};
      end else if (is_slli && rd == rs1 && rd != 5'd0) begin
         c_hit = 1'b1;
         c_par = {4'b0000, rd, I_data[24:20], 2'b10};
      end else if (is_add && rs1 == 5'd0 && rd != 5'd0 && rs2 != 5'd0) begin
         c_hit = 1'b1;
         c_par = {4'b1000, rd, rs2, 2'b10};
      end else if (is_add && rd == rs1 && rd != 5'd0 && rs2 != 5'd0) begin
         c_hit = 1'b1;
         c_par = {4'b1001, rd, rs2, 2'b10};
      end else if (is_jalr && rd == 5'd0 && rs1 != 5'd0 && imm_zero) begin
         c_hit = 1'b1;
         c_par = {4'b1000, rs1, 5'b00000, 2'b10};
      end else if (I_data == 32'h0010_0073) begin
         c_hit = 1'b1;
         c_par = 16'h9002;
      end else if (is_lw && rd[4:3] == 2'b01 && rs1[4:3] == 2'b01 && lw_off_ok) begin
         c_hit = 1'b1;
         c_par = {3'b010, I_data[25:23], rs1[2:0], I_data[22], I_data[26], rd[2:0], 2'b00};
      end else if (is_sw && rs1[4:3] == 2'b01 && rs2[4:3] == 2'b01 && sw_off_ok) begin
         c_hit = 1'b1;
         c_par = {3'b110, I_data[25], I_data[11:10], rs1[2:0], I_data[9], I_data[26],
                  rs2[2:0], 2'b00};
      end
      if (ENABLE_RVC == 0) c_hit = 1'b0;
   end

   assign slot_free = !out_vld_q || I_ready;
   assign flush_go  = I_flush && slot_free;
   assign take      = I_valid && slot_free && !I_flush;

   always_comb begin
      state_d    = state_q;
      hbuf_d     = hbuf_q;
      out_vld_d  = out_vld_q && !I_ready;
      out_word_d = out_word_q;
      err_d      = err_q;
      comp_inc   = 1'b0;
      if (flush_go) begin
         if (state_q == ST_HALF) begin
            out_vld_d  = 1'b1;
            out_word_d = {16'h0001, hbuf_q};
            state_d    = ST_EMPTY;
         end
      end else if (take) begin
         if (I_data[1:0] != 2'b11) begin
            err_d = 1'b1;
         end else if (c_hit) begin
            comp_inc = 1'b1;
            if (state_q == ST_EMPTY) begin
               hbuf_d  = c_par;
               state_d = ST_HALF;
            end else begin
               out_vld_d  = 1'b1;
               out_word_d = {c_par, hbuf_q};
               state_d    = ST_EMPTY;
            end
         end else if (state_q == ST_EMPTY) begin
            out_vld_d  = 1'b1;
            out_word_d = I_data;
         end else begin
            out_vld_d  = 1'b1;
            out_word_d = {I_data[15:0], hbuf_q};
            hbuf_d     = I_data[31:16];
         end
      end
   end

   assign cnt_comp_d  = (comp_inc && cnt_comp_q != CNT_MAX) ? cnt_comp_q + CNT_W'(1) : cnt_comp_q;
   assign cnt_words_d = (out_vld_q && I_ready && cnt_words_q != CNT_MAX) ?
                        cnt_words_q + CNT_W'(1) : cnt_words_q;

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state_q     <= ST_EMPTY;
         hbuf_q      <= 16'h0000;
         out_vld_q   <= 1'b0;
         out_word_q  <= 32'h0;
         err_q       <= 1'b0;
         cnt_comp_q  <= '0;
         cnt_words_q <= '0;
      end else begin
         state_q     <= state_d;
         hbuf_q      <= hbuf_d;
         out_vld_q   <= out_vld_d;
         out_word_q  <= out_word_d;
         err_q       <= err_d;
         cnt_comp_q  <= cnt_comp_d;
         cnt_words_q <= cnt_words_d;
      end
   end

   assign O_accept     = slot_free && !I_flush;
   assign O_flush_done = flush_go;
   assign O_valid      = out_vld_q;
   assign O_word       = out_word_q;
   assign O_err        = err_q;
   assign O_cnt_comp   = cnt_comp_q;
   assign O_cnt_words  = cnt_words_q;

endmodule
